// File: rtl/input_conditioner_bank.sv
// Multi-channel synchronizer + debouncer with registered edge strobes.
// Each channel is independent; one clock and one synchronous reset.
module input_conditioner_bank #(
    parameter int CHANNELS     = 3,
    parameter int WAITTIME     = 3,
    parameter int COUNTERWIDTH = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] noisysignal,
    output logic [CHANNELS-1:0] conditioned,
    output logic [CHANNELS-1:0] positiveedge,
    output logic [CHANNELS-1:0] negativeedge
);

    localparam logic [COUNTERWIDTH-1:0] WAIT_C = COUNTERWIDTH'(WAITTIME);

    logic [CHANNELS-1:0]     r_sync0;
    logic [CHANNELS-1:0]     r_sync1;
    logic [CHANNELS-1:0]     r_cond;
    logic [CHANNELS-1:0]     r_pos;
    logic [CHANNELS-1:0]     r_neg;
    logic [COUNTERWIDTH-1:0] r_cnt [CHANNELS];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync0 <= '0;
            r_sync1 <= '0;
            r_cond  <= '0;
            r_pos   <= '0;
            r_neg   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync0 <= noisysignal;
            r_sync1 <= r_sync0;
            for (int i = 0; i < CHANNELS; i++) begin
                if (r_sync1[i] == r_cond[i]) begin
                    // Stable: any matching cycle discards a pending count.
                    r_cnt[i] <= '0;
                    r_pos[i] <= 1'b0;
                    r_neg[i] <= 1'b0;
                end else if (r_cnt[i] == WAIT_C) begin
                    r_cond[i] <= r_sync1[i];
                    r_cnt[i]  <= '0;
                    r_pos[i]  <= r_sync1[i];
                    r_neg[i]  <= ~r_sync1[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                    r_pos[i] <= 1'b0;
                    r_neg[i] <= 1'b0;
                end
            end
        end
    end

    assign conditioned  = r_cond;
    assign positiveedge = r_pos;
    assign negativeedge = r_neg;

endmodule
